// File: rtl/mips_pkg.sv
// Shared types and sizes for the single-cycle MIPS datapath.
// The register file and its read-port helper both import this package.
package mips_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     word_t;

    localparam reg_addr_t ZERO_REG = 5'd0;

    // Register 0 is architecturally constant, so both the read and write paths test for it.
    function automatic logic is_zero_reg(input reg_addr_t addr);
        return addr == ZERO_REG;
    endfunction

endpackage

// File: rtl/mips_regfile_read_port.sv
// One combinational read port: selects a word from the flattened register array
// and forces register 0 to read as zero regardless of what storage holds.
module mips_regfile_read_port
    import mips_pkg::*;
#(
    parameter int P_DATA_W   = DATA_W,
    parameter int P_NUM_REGS = NUM_REGS,
    parameter int P_ADDR_W   = $clog2(P_NUM_REGS)
) (
    input  logic [P_NUM_REGS-1:0][P_DATA_W-1:0] regs,
    input  logic [P_ADDR_W-1:0]                 addr,
    output logic [P_DATA_W-1:0]                 data
);

    always_comb begin
        data = regs[addr];
        if (addr == '0) begin
            data = '0;
        end
    end

endmodule

// File: rtl/mips_regfile.sv
// 32 x 32-bit general-purpose register file: two combinational read ports (rs, rt),
// one clocked write port (rd). Register 0 reads as zero; writes freeze while halted.
module mips_regfile
    import mips_pkg::*;
#(
    parameter int DATA_W   = mips_pkg::DATA_W,
    parameter int NUM_REGS = mips_pkg::NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic [ADDR_W-1:0] rs_num,
    input  logic [ADDR_W-1:0] rt_num,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic [ADDR_W-1:0] rd_num,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_we,
    input  logic              halted
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs_d;
    logic                            wr_commit;

    // rst_b is active-high despite its name; it wins over any write in the same cycle.
    assign wr_commit = rd_we && !halted && (rd_num != '0) && !rst_b;

    always_comb begin
        regs_d = regs_q;
        if (rst_b) begin
            regs_d = '0;
        end else if (wr_commit) begin
            regs_d[rd_num] = rd_data;
        end
    end

    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    mips_regfile_read_port #(
        .P_DATA_W   (DATA_W),
        .P_NUM_REGS (NUM_REGS),
        .P_ADDR_W   (ADDR_W)
    ) u_rs_port (
        .regs (regs_q),
        .addr (rs_num),
        .data (rs_data)
    );

    mips_regfile_read_port #(
        .P_DATA_W   (DATA_W),
        .P_NUM_REGS (NUM_REGS),
        .P_ADDR_W   (ADDR_W)
    ) u_rt_port (
        .regs (regs_q),
        .addr (rt_num),
        .data (rt_data)
    );

endmodule

// File: tb/tb_mips_regfile.sv
// Directed bench for mips_regfile: reset sweeps, a table of write/read vectors,
// and hand-written sequences for pre/post-edge visibility and reset priority.
module tb_mips_regfile;

    logic        clk;
    logic        rst_b;
    logic [4:0]  rs_num;
    logic [4:0]  rt_num;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [4:0]  rd_num;
    logic [31:0] rd_data;
    logic        rd_we;
    logic        halted;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic        rst;
        logic        we;
        logic        hlt;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] exp_rs;
        logic [31:0] exp_rt;
    } vec_t;

    vec_t vecs[$];

    mips_regfile dut (
        .clk     (clk),
        .rst_b   (rst_b),
        .rs_num  (rs_num),
        .rt_num  (rt_num),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .rd_num  (rd_num),
        .rd_data (rd_data),
        .rd_we   (rd_we),
        .halted  (halted)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic we, input logic hlt,
                         input logic [4:0] rd, input logic [31:0] wd,
                         input logic [4:0] rs, input logic [4:0] rt);
        @(negedge clk);
        rst_b   = rst;
        rd_we   = we;
        halted  = hlt;
        rd_num  = rd;
        rd_data = wd;
        rs_num  = rs;
        rt_num  = rt;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, rs_num, rt_num);
    endtask

    task automatic sweep_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            rs_num = 5'(i);
            rt_num = 5'(31 - i);
            #1;
            check($sformatf("%s_rs_r%0d", tag, i), rs_data, 32'h0);
            check($sformatf("%s_rt_r%0d", tag, 31 - i), rt_data, 32'h0);
        end
    endtask

    task automatic add_vec(input logic rst, input logic we, input logic hlt,
                           input logic [4:0] rd, input logic [31:0] wd,
                           input logic [4:0] rs, input logic [4:0] rt,
                           input logic [31:0] ers, input logic [31:0] ert);
        vec_t v;
        v.rst = rst; v.we = we; v.hlt = hlt; v.rd = rd; v.wdata = wd;
        v.rs = rs; v.rt = rt; v.exp_rs = ers; v.exp_rt = ert;
        vecs.push_back(v);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        // Expected read values are those after the edge on which the vector is applied.
        //       rst   we    hlt   rd     wdata          rs     rt     exp_rs         exp_rt
        add_vec(1'b0, 1'b1, 1'b0, 5'd0,  32'h1234_5678, 5'd0,  5'd5,  32'h0000_0000, 32'hDEAD_BEEF);
        add_vec(1'b0, 1'b1, 1'b0, 5'd7,  32'hA5A5_A5A5, 5'd7,  5'd0,  32'hA5A5_A5A5, 32'h0000_0000);
        add_vec(1'b0, 1'b1, 1'b1, 5'd7,  32'h0000_0000, 5'd7,  5'd7,  32'hA5A5_A5A5, 32'hA5A5_A5A5);
        add_vec(1'b0, 1'b1, 1'b1, 5'd3,  32'h0000_0001, 5'd3,  5'd5,  32'h0000_0000, 32'hDEAD_BEEF);
        add_vec(1'b0, 1'b1, 1'b0, 5'd3,  32'h1111_1111, 5'd3,  5'd4,  32'h1111_1111, 32'h0000_0000);
        add_vec(1'b0, 1'b1, 1'b0, 5'd4,  32'hFFFF_FFFF, 5'd3,  5'd4,  32'h1111_1111, 32'hFFFF_FFFF);
        add_vec(1'b0, 1'b0, 1'b0, 5'bx,  32'h0000_0000, 5'd5,  5'd7,  32'hDEAD_BEEF, 32'hA5A5_A5A5);
        add_vec(1'b0, 1'b1, 1'b0, 5'd31, 32'h8000_0001, 5'd31, 5'd31, 32'h8000_0001, 32'h8000_0001);
        add_vec(1'b0, 1'b1, 1'b0, 5'd5,  32'h0000_0042, 5'd5,  5'd4,  32'h0000_0042, 32'hFFFF_FFFF);
        add_vec(1'b1, 1'b1, 1'b0, 5'd9,  32'h0000_0055, 5'd9,  5'd5,  32'h0000_0000, 32'h0000_0000);
        add_vec(1'b0, 1'b0, 1'b0, 5'd0,  32'h0000_0000, 5'd9,  5'd31, 32'h0000_0000, 32'h0000_0000);

        rst_b = 1'b1; rd_we = 1'b0; halted = 1'b0;
        rd_num = '0; rd_data = '0; rs_num = '0; rt_num = '0;
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        sweep_zero("reset");

        // Write r5: old value before the edge, new value right after it.
        drive(1'b0, 1'b1, 1'b0, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5);
        #1;
        check("r5_rs_before_edge", rs_data, 32'h0);
        check("r5_rt_before_edge", rt_data, 32'h0);
        @(posedge clk);
        #1;
        check("r5_rs_after_edge", rs_data, 32'hDEAD_BEEF);
        check("r5_rt_after_edge", rt_data, 32'hDEAD_BEEF);

        foreach (vecs[k]) begin
            drive(vecs[k].rst, vecs[k].we, vecs[k].hlt, vecs[k].rd, vecs[k].wdata,
                  vecs[k].rs, vecs[k].rt);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_rs", k), rs_data, vecs[k].exp_rs);
            check($sformatf("vec%0d_rt", k), rt_data, vecs[k].exp_rt);
            if (k == 5) begin
                n_cmp++;
                if ($signed(rt_data) != -32'sd1) begin
                    n_bad++;
                    $display("FAIL vec5_rt_signed: got %0d, expected -1", $signed(rt_data));
                end
            end
        end

        // Everything written before the reset vector must be gone.
        idle();
        sweep_zero("post_reset");

        // Halt asserted over several edges with writes offered; array stays frozen, reads live.
        drive(1'b0, 1'b1, 1'b0, 5'd12, 32'hCAFE_F00D, 5'd12, 5'd0);
        drive(1'b0, 1'b1, 1'b1, 5'd12, 32'h0BAD_0BAD, 5'd12, 5'd0);
        drive(1'b0, 1'b1, 1'b1, 5'd13, 32'h0BAD_0BAD, 5'd12, 5'd13);
        @(posedge clk);
        #1;
        check("halt_r12_frozen", rs_data, 32'hCAFE_F00D);
        check("halt_r13_untouched", rt_data, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 5'd13, 32'h7777_0000, 5'd12, 5'd13);
        @(posedge clk);
        #1;
        check("unhalt_r12", rs_data, 32'hCAFE_F00D);
        check("unhalt_r13_written", rt_data, 32'h7777_0000);

        idle();
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
